bsg_link_upstream_arbiter: RTL
==============================

# bsg_link_upstream_arbiter

Round-robin arbiter with bounded burst locking. It merges `num_in_p` core-side valid/yumi channels onto the single valid/ready core input of the DDR link upstream. The winning channel's index is carried in the top bits of each output word so the far side can demultiplex. A one-entry registered output stage drives the link, and `en_i` allows the link to be drained before link reset or reconfiguration.

## Interface
- `num_in_p`, 4: number of requesting channels (≥2).
- `width_p`, 64: output word width; matches the link core data width.
- `id_width_p`, `$clog2(num_in_p)`: width of the channel-id field.
- `payload_width_p`, `width_p - id_width_p`: per-channel payload width.
- `max_burst_p`, 4: maximum consecutive words granted to one channel (≥1).

Ports:
- `clk_i` in 1: core clock; the only clock.
- `reset_i` in 1: reset, asynchronous and active-high.
- `en_i` in 1: grant enable; when low, no new words are accepted.
- `data_i` in `num_in_p*payload_width_p`: channel payloads; channel i occupies slice i.
- `v_i` in `num_in_p`: per-channel valid.
- `yumi_o` out `num_in_p`: per-channel consume strobe; one-hot or zero.
- `data_o` out `width_p`: `{id, payload}` toward the link `core_data_i`.
- `valid_o` out 1: output word valid.
- `ready_i` in 1: link `core_ready_o`.
- `busy_o` out 1: high while `valid_o` is high or a burst lock is held.

## Operation
- State registers:
  - `valid_o_r`, `data_o_r`: output stage.
  - `owner_r[id_width_p]`: current or last owner.
  - `lock_r`: burst lock held.
  - `cnt_r`: words sent by the current owner in this burst; range 0..`max_burst_p`.
- Accept condition: `accept = en_i & (~valid_o_r | ready_i)`. The output slot is free when empty or draining this cycle.
- Winner selection, only when `accept` and `|v_i`:
  - If `lock_r & v_i[owner_r]`, the winner is `owner_r`.
  - Otherwise, the winner is the first valid channel scanning `owner_r+1`, `owner_r+2`, … with wrap-around; `owner_r` itself is checked last.
- On transfer (`accept & |v_i`):
  - `yumi_o[winner]=1`.
  - `data_o_r <= {winner, data_i[winner]}`; `valid_o_r <= 1`.
  - If `lock_r & winner==owner_r`, then `cnt_r <= cnt_r+1`. Otherwise `owner_r <= winner` and `cnt_r <= 1`.
  - `lock_r <= (new cnt_r < max_burst_p)`. Reaching `max_burst_p` releases the lock, so the next grant rotates past the owner.
- Lock release without transfer: if `accept & lock_r & ~v_i[owner_r]`, then `lock_r <= 0`. A gap from the owner ends its burst even if other channels are idle.
- Drain without refill: `valid_o_r & ready_i` with no transfer gives `valid_o_r <= 0`. `data_o_r` holds its value.
- `en_i=0`:
  - `yumi_o=0`; no grant state changes.
  - An already-registered word still drains on `ready_i`.
  - `lock_r`, `owner_r` and `cnt_r` are retained.
- `max_burst_p=1` degenerates to pure round robin; `lock_r` never sets.
- Reset values: `valid_o=0`, `data_o=0`, `lock_r=0`, `cnt_r=0`, `owner_r=num_in_p-1` (so channel 0 has first priority), `busy_o=0`. While `reset_i` is high, `yumi_o=0` regardless of `v_i`.
- Reset mid-operation: the registered word is discarded. The link is reset alongside, so there is no recovery obligation.

## Timing
- `yumi_o` is combinational from `v_i`, `en_i`, `ready_i` and state in the same cycle. Channels must not make `v_i` depend on `yumi_o`.
- Latency is 1 cycle: a word yumi'd in cycle N appears on `data_o`/`valid_o` in cycle N+1.
- Throughput: one word per cycle when `ready_i` is held high. There are no bubbles between owners or between bursts.
- `data_o`/`valid_o` are register outputs and stay stable while `valid_o & ~ready_i`.
- `busy_o` is combinational: `valid_o_r | lock_r`.

## Test plan
- **Reset and first grant.** Reset, then `v_i=4'b1111` with `ready_i=1`. Required: `yumi_o=0001` for 4 cycles (channel 0 burst), then `0010` ×4, `0100` ×4, `1000` ×4. `data_o[63:62]` tracks the id one cycle later. `valid_o=0`, `data_o=0` during reset.
- **Early burst end.** Only channel 2 valid for 2 cycles, then `v_i=4'b1001`. Required: channel 2 gets 2 words; the lock releases on its gap; channel 3 wins before channel 0.
- **Backpressure.** `ready_i=0` while `valid_o=1` and `v_i=4'b0001`. Required: `yumi_o=0`; `data_o` stable for the stall. When `ready_i` rises, the held word drains and the next word loads in the same cycle, with no bubble.
- **Enable gating.** Deassert `en_i` mid-burst with `cnt_r=2`. Required: no yumi; the pending word drains; `busy_o` stays 1 from the lock. After re-enable, the owner finishes exactly 2 more words.
- **Pure round robin.** Set `max_burst_p=1` with `v_i=4'b0101`. Required: `yumi_o` alternates `0001`/`0100` every cycle; `lock_r` never sets.
- **Asynchronous reset.** Assert `reset_i` between clock edges while `valid_o=1`. Required: `valid_o=0` immediately, before the next edge, and `yumi_o=0`.

Source files
------------

// File: rtl/bsg_link_upstream_arbiter_if.sv
// Channel-side and link-side signals of the upstream arbiter.
// slave = arbiter, master = channels and link driving it.
interface bsg_link_upstream_arbiter_if #(
  parameter int num_in_p        = 4,
  parameter int width_p         = 64,
  parameter int id_width_p      = $clog2(num_in_p),
  parameter int payload_width_p = width_p - id_width_p
);
  logic                                en_i;
  logic [num_in_p*payload_width_p-1:0] data_i;
  logic [num_in_p-1:0]                 v_i;
  logic [num_in_p-1:0]                 yumi_o;
  logic [width_p-1:0]                  data_o;
  logic                                valid_o;
  logic                                ready_i;
  logic                                busy_o;

  modport slave  (input  en_i, data_i, v_i, ready_i,
                  output yumi_o, data_o, valid_o, busy_o);
  modport master (output en_i, data_i, v_i, ready_i,
                  input  yumi_o, data_o, valid_o, busy_o);
endinterface

// File: rtl/bsg_link_upstream_arbiter.sv
// Round-robin arbiter with bounded burst locking feeding the link upstream
// through a one-entry output register; the channel id rides in the top bits.
module bsg_link_upstream_arbiter #(
  parameter int num_in_p        = 4,
  parameter int width_p         = 64,
  parameter int id_width_p      = $clog2(num_in_p),
  parameter int payload_width_p = width_p - id_width_p,
  parameter int max_burst_p     = 4
) (
  input logic clk_i,
  input logic reset_i,
  bsg_link_upstream_arbiter_if.slave link
);
  // One spare bit so cnt_r+1 on a dead path can never wrap below max_burst_p
  localparam int cnt_width_lp = $clog2(max_burst_p + 2);
  localparam logic [cnt_width_lp-1:0] max_burst_lp = cnt_width_lp'(max_burst_p);

  logic                    valid_r;
  logic [width_p-1:0]      data_r;
  logic [id_width_p-1:0]   owner_r, winner, idx_id;
  logic                    lock_r, found, accept, xfer, same_owner;
  logic [cnt_width_lp-1:0] cnt_r, cnt_nxt;
  int                      idx;

  // Locked owner keeps the grant; otherwise scan from owner_r+1, owner last.
  always_comb begin
    winner = owner_r;
    found  = 1'b0;
    idx    = 0;
    idx_id = '0;
    if (lock_r && link.v_i[owner_r]) begin
      found = 1'b1;
    end else begin
      for (int k = 1; k <= num_in_p; k++) begin
        idx = int'(owner_r) + k;
        if (idx >= num_in_p) idx = idx - num_in_p;
        idx_id = id_width_p'(idx);
        if (!found && link.v_i[idx_id]) begin
          winner = idx_id;
          found  = 1'b1;
        end
      end
    end
  end

  assign accept     = link.en_i & (~valid_r | link.ready_i);
  assign xfer       = accept & found & ~reset_i;
  assign same_owner = lock_r && (winner == owner_r);
  assign cnt_nxt    = same_owner ? cnt_r + 1'b1 : cnt_width_lp'(1);

  always_comb begin
    link.yumi_o = '0;
    if (xfer) link.yumi_o[winner] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_r <= 1'b0;
      data_r  <= '0;
      owner_r <= id_width_p'(num_in_p - 1);
      lock_r  <= 1'b0;
      cnt_r   <= '0;
    end else if (xfer) begin
      valid_r <= 1'b1;
      data_r  <= {winner, link.data_i[int'(winner)*payload_width_p +: payload_width_p]};
      owner_r <= winner;
      cnt_r   <= cnt_nxt;
      lock_r  <= (cnt_nxt < max_burst_lp);
    end else begin
      if (valid_r && link.ready_i) valid_r <= 1'b0;
      // A gap from the owner ends its burst even if nobody else is waiting
      if (accept && lock_r && !link.v_i[owner_r]) lock_r <= 1'b0;
    end
  end

  assign link.data_o  = data_r;
  assign link.valid_o = valid_r;
  assign link.busy_o  = valid_r | lock_r;
endmodule
